// File: rtl/uart_mmio_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// uart_mmio_pkg : register map, CON bit positions and engine state encodings
// Rev 1.0
// ---------------------------------------------------------------------------
package uart_mmio_pkg;

  localparam logic [31:0] TXD_OFS = 32'h0000_0000;
  localparam logic [31:0] RXD_OFS = 32'h0000_0004;
  localparam logic [31:0] CON_OFS = 32'h0000_0008;

  localparam int CON_TX_IRQ_EN  = 0;
  localparam int CON_RX_IRQ_EN  = 1;
  localparam int CON_TX_DONE    = 2;
  localparam int CON_RX_VALID   = 3;
  localparam int CON_TX_BUSY    = 4;
  localparam int CON_RX_OVERRUN = 5;
  localparam int CON_FRAME_ERR  = 6;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_e;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_e;

endpackage
`default_nettype wire

// File: rtl/uart_mmio_responder_rx.sv
`default_nettype none
// ---------------------------------------------------------------------------
// uart_rx_core : 8N1 receiver, synchronizer + mid-bit sampling FSM + shifter
// Rev 1.0
// ---------------------------------------------------------------------------
module uart_rx_core
  import uart_mmio_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rxd,
  output logic       frame_ok,
  output logic       frame_bad,
  output logic [7:0] rx_byte
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

  logic             sync1_q, sync2_q;
  rx_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             ok_q, ok_d;
  logic             bad_q, bad_d;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + CNT_W'(1);
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    ok_d      = 1'b0;
    bad_d     = 1'b0;
    case (state_q)
      RX_IDLE: begin
        cnt_d = '0;
        if (!sync2_q) state_d = RX_START;
      end
      RX_START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d     = '0;
          bit_idx_d = '0;
          state_d   = sync2_q ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d     = '0;
          shift_d   = {sync2_q, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) state_d = RX_STOP;
        end
      end
      RX_STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          ok_d    = sync2_q;
          bad_d   = !sync2_q;
          state_d = RX_IDLE;
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  // Synchronizer resets to the idle-high line level so reset release is not a start bit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      state_q   <= RX_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      ok_q      <= 1'b0;
      bad_q     <= 1'b0;
    end else begin
      sync1_q   <= rxd;
      sync2_q   <= sync1_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      ok_q      <= ok_d;
      bad_q     <= bad_d;
    end
  end

  assign frame_ok  = ok_q;
  assign frame_bad = bad_q;
  assign rx_byte   = shift_q;

endmodule
`default_nettype wire

// File: rtl/uart_mmio_responder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// uart_mmio_responder : bus-mapped UART with TXD/RXD/CON registers and IRQ
// Rev 1.0
// ---------------------------------------------------------------------------
module uart_mmio_responder
  import uart_mmio_pkg::*;
#(
  parameter int          CLKS_PER_BIT = 434,
  parameter logic [31:0] BASE_ADDR    = 32'h4000_0018
) (
  input  logic        reset,
  input  logic        clk,
  input  logic        rd,
  input  logic        wr,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irqout,
  input  logic        uart_rxd,
  output logic        uart_txd
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic sel_txd, sel_rxd, sel_con;
  logic con_wr, rxd_rd, tx_busy, tx_accept, tx_finish;
  logic rx_ok, rx_bad;
  logic [7:0] rx_core_byte;
  logic [31:0] con_val;
  logic unused_wdata;

  tx_state_e        tx_state_q, tx_state_d;
  logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]       tx_bit_q, tx_bit_d;
  logic [7:0]       tx_shift_q, tx_shift_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic             txd_q, txd_d;

  logic       tx_irq_en_q, tx_irq_en_d;
  logic       rx_irq_en_q, rx_irq_en_d;
  logic       tx_done_q, tx_done_d;
  logic       rx_valid_q, rx_valid_d;
  logic       rx_overrun_q, rx_overrun_d;
  logic       frame_err_q, frame_err_d;
  logic [7:0] rx_byte_q, rx_byte_d;

  assign sel_txd      = (addr == BASE_ADDR + TXD_OFS);
  assign sel_rxd      = (addr == BASE_ADDR + RXD_OFS);
  assign sel_con      = (addr == BASE_ADDR + CON_OFS);
  assign con_wr       = wr && sel_con;
  assign rxd_rd       = rd && sel_rxd;
  assign tx_busy      = (tx_state_q != TX_IDLE);
  assign tx_accept    = wr && sel_txd && !tx_busy;
  assign unused_wdata = ^wdata[31:7];

  uart_rx_core #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk      (clk),
    .reset    (reset),
    .rxd      (uart_rxd),
    .frame_ok (rx_ok),
    .frame_bad(rx_bad),
    .rx_byte  (rx_core_byte)
  );

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q + CNT_W'(1);
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_data_d  = tx_data_q;
    txd_d      = txd_q;
    tx_finish  = 1'b0;
    case (tx_state_q)
      TX_IDLE: begin
        tx_cnt_d = '0;
        txd_d    = 1'b1;
        if (tx_accept) begin
          tx_state_d = TX_START;
          tx_shift_d = wdata[7:0];
          tx_data_d  = wdata[7:0];
          txd_d      = 1'b0;
        end
      end
      TX_START: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d   = '0;
          tx_bit_d   = '0;
          txd_d      = tx_shift_q[0];
          tx_state_d = TX_DATA;
        end
      end
      TX_DATA: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d = '0;
          if (tx_bit_q == 3'd7) begin
            txd_d      = 1'b1;
            tx_state_d = TX_STOP;
          end else begin
            tx_bit_d   = tx_bit_q + 3'd1;
            tx_shift_d = {1'b0, tx_shift_q[7:1]};
            txd_d      = tx_shift_q[1];
          end
        end
      end
      TX_STOP: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d   = '0;
          tx_state_d = TX_IDLE;
          tx_finish  = 1'b1;
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  // Sticky flags: the hardware set is applied after the write-1-clear so it wins.
  always_comb begin
    tx_irq_en_d  = tx_irq_en_q;
    rx_irq_en_d  = rx_irq_en_q;
    tx_done_d    = tx_done_q;
    rx_valid_d   = rx_valid_q;
    rx_overrun_d = rx_overrun_q;
    frame_err_d  = frame_err_q;
    rx_byte_d    = rx_byte_q;
    if (con_wr) begin
      tx_irq_en_d = wdata[CON_TX_IRQ_EN];
      rx_irq_en_d = wdata[CON_RX_IRQ_EN];
      if (wdata[CON_TX_DONE])    tx_done_d    = 1'b0;
      if (wdata[CON_RX_OVERRUN]) rx_overrun_d = 1'b0;
      if (wdata[CON_FRAME_ERR])  frame_err_d  = 1'b0;
    end
    if (rxd_rd) rx_valid_d = 1'b0;
    if (tx_finish) tx_done_d = 1'b1;
    if (rx_bad) frame_err_d = 1'b1;
    if (rx_ok) begin
      rx_byte_d  = rx_core_byte;
      rx_valid_d = 1'b1;
      if (rx_valid_q && !rxd_rd) rx_overrun_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_state_q   <= TX_IDLE;
      tx_cnt_q     <= '0;
      tx_bit_q     <= '0;
      tx_shift_q   <= '0;
      tx_data_q    <= '0;
      txd_q        <= 1'b1;
      tx_irq_en_q  <= 1'b0;
      rx_irq_en_q  <= 1'b0;
      tx_done_q    <= 1'b0;
      rx_valid_q   <= 1'b0;
      rx_overrun_q <= 1'b0;
      frame_err_q  <= 1'b0;
      rx_byte_q    <= '0;
    end else begin
      tx_state_q   <= tx_state_d;
      tx_cnt_q     <= tx_cnt_d;
      tx_bit_q     <= tx_bit_d;
      tx_shift_q   <= tx_shift_d;
      tx_data_q    <= tx_data_d;
      txd_q        <= txd_d;
      tx_irq_en_q  <= tx_irq_en_d;
      rx_irq_en_q  <= rx_irq_en_d;
      tx_done_q    <= tx_done_d;
      rx_valid_q   <= rx_valid_d;
      rx_overrun_q <= rx_overrun_d;
      frame_err_q  <= frame_err_d;
      rx_byte_q    <= rx_byte_d;
    end
  end

  always_comb begin
    con_val                 = '0;
    con_val[CON_TX_IRQ_EN]  = tx_irq_en_q;
    con_val[CON_RX_IRQ_EN]  = rx_irq_en_q;
    con_val[CON_TX_DONE]    = tx_done_q;
    con_val[CON_RX_VALID]   = rx_valid_q;
    con_val[CON_TX_BUSY]    = tx_busy;
    con_val[CON_RX_OVERRUN] = rx_overrun_q;
    con_val[CON_FRAME_ERR]  = frame_err_q;
    rdata = '0;
    if (rd) begin
      if (sel_txd)      rdata = {24'b0, tx_data_q};
      else if (sel_rxd) rdata = {24'b0, rx_byte_q};
      else if (sel_con) rdata = con_val;
    end
  end

  assign irqout   = (tx_irq_en_q & tx_done_q) | (rx_irq_en_q & rx_valid_q);
  assign uart_txd = txd_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_mmio_responder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_uart_mmio_responder : directed + randomized bench with a register-level model
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_uart_mmio_responder;

  localparam int          CPB    = 16;
  localparam logic [31:0] BASE   = 32'h4000_0018;
  localparam logic [31:0] A_TXD  = BASE;
  localparam logic [31:0] A_RXD  = BASE + 32'd4;
  localparam logic [31:0] A_CON  = BASE + 32'd8;
  localparam logic [31:0] A_NONE = BASE + 32'd12;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        rd = 1'b0;
  logic        wr = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        uart_rxd = 1'b1;
  logic [31:0] rdata;
  logic        irqout;
  logic        uart_txd;

  int checks = 0;
  int failures = 0;

  // Expected architectural state
  bit       m_tx_irq_en, m_rx_irq_en, m_tx_done, m_rx_valid, m_overrun, m_ferr;
  bit [7:0] m_tx_data, m_rx_byte;

  always #5 clk = ~clk;

  uart_mmio_responder #(
    .CLKS_PER_BIT(CPB),
    .BASE_ADDR   (BASE)
  ) dut (
    .reset   (reset),
    .clk     (clk),
    .rd      (rd),
    .wr      (wr),
    .addr    (addr),
    .wdata   (wdata),
    .rdata   (rdata),
    .irqout  (irqout),
    .uart_rxd(uart_rxd),
    .uart_txd(uart_txd)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_con(input bit busy);
    return {25'b0, m_ferr, m_overrun, busy, m_rx_valid, m_tx_done, m_rx_irq_en, m_tx_irq_en};
  endfunction

  function automatic logic exp_irq();
    return (m_tx_irq_en && m_tx_done) || (m_rx_irq_en && m_rx_valid);
  endfunction

  task automatic model_reset();
    m_tx_irq_en = 0; m_rx_irq_en = 0; m_tx_done = 0; m_rx_valid = 0;
    m_overrun = 0; m_ferr = 0; m_tx_data = 0; m_rx_byte = 0;
  endtask

  // Combinational read without crossing a clock edge (no side effects).
  task automatic peek(input logic [31:0] a, output logic [31:0] d);
    addr = a; rd = 1'b1;
    #1 d = rdata;
    rd = 1'b0;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    addr = a; wdata = d; wr = 1'b1;
    @(negedge clk);
    wr = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    @(negedge clk);
    addr = a; rd = 1'b1;
    #1 d = rdata;
    @(negedge clk);
    rd = 1'b0;
  endtask

  task automatic con_write(input logic [31:0] d);
    bus_write(A_CON, d);
    m_tx_irq_en = d[0];
    m_rx_irq_en = d[1];
    if (d[2]) m_tx_done = 0;
    if (d[5]) m_overrun = 0;
    if (d[6]) m_ferr = 0;
  endtask

  task automatic check_regs(input string tag);
    logic [31:0] d;
    @(negedge clk);
    peek(A_CON, d); check({tag, "_con"}, d, exp_con(1'b0));
    check({tag, "_irq"}, {31'b0, irqout}, {31'b0, exp_irq()});
    peek(A_RXD, d); check({tag, "_rxd"}, d, {24'b0, m_rx_byte});
    peek(A_TXD, d); check({tag, "_txd"}, d, {24'b0, m_tx_data});
  endtask

  // Transmit one byte and watch the serial line mid-bit; optionally try to
  // overwrite TXD mid-frame and on the completion edge.
  task automatic tx_frame(input logic [7:0] b, input bit inject);
    logic [9:0]  bits;
    logic [31:0] d;
    bits = {1'b1, b, 1'b0};
    @(negedge clk);
    addr = A_TXD; wdata = {24'b0, b}; wr = 1'b1;
    @(negedge clk);
    wr = 1'b0;
    m_tx_data = b;
    for (int cyc = 1; cyc <= 165; cyc++) begin
      if (cyc % CPB == CPB / 2 && cyc <= 10 * CPB)
        check($sformatf("tx_bit%0d", cyc / CPB), {31'b0, uart_txd}, {31'b0, bits[cyc / CPB]});
      if (cyc == 20) begin
        peek(A_CON, d); check("tx_busy_con", d, exp_con(1'b1));
      end
      if (inject && cyc == 40) begin
        addr = A_TXD; wdata = 32'h3C; wr = 1'b1;
      end
      if (cyc == 41) wr = 1'b0;
      if (cyc == 160) begin
        peek(A_CON, d); check("tx_last_busy_con", d, exp_con(1'b1));
        if (inject) begin
          addr = A_TXD; wdata = 32'h3C; wr = 1'b1;
        end
      end
      if (cyc == 161) begin
        wr = 1'b0;
        m_tx_done = 1;
        peek(A_CON, d); check("tx_done_con", d, exp_con(1'b0));
        check("tx_done_irq", {31'b0, irqout}, {31'b0, exp_irq()});
      end
      if (cyc >= 161) check("tx_idle_line", {31'b0, uart_txd}, 32'd1);
      if (cyc == 165) begin
        peek(A_TXD, d); check("tx_latched", d, {24'b0, m_tx_data});
      end
      @(negedge clk);
    end
  endtask

  // Drive one 8N1 frame; rd_at != 0 issues an RXD read on the edge just
  // before negedge rd_at. lat reports when rx_valid first appears.
  task automatic rx_frame(input logic [7:0] b, input bit stop, input int rd_at, output int lat);
    logic [31:0] d;
    lat = 0;
    for (int cyc = 0; cyc < 180; cyc++) begin
      @(negedge clk);
      if (cyc < 16)       uart_rxd = 1'b0;
      else if (cyc < 144) uart_rxd = b[(cyc - 16) / 16];
      else if (cyc < 160) uart_rxd = stop;
      else                uart_rxd = 1'b1;
      if (rd_at != 0 && cyc == rd_at - 1) begin
        addr = A_RXD; rd = 1'b1;
      end else begin
        rd = 1'b0;
        if (lat == 0) begin
          peek(A_CON, d);
          if (d[3]) lat = cyc;
        end
      end
    end
    rd = 1'b0;
    // Reference behaviour for a completed frame
    if (stop) begin
      if (m_rx_valid && rd_at == 0) m_overrun = 1;
      m_rx_byte  = b;
      m_rx_valid = 1;
    end else begin
      m_ferr = 1;
    end
  endtask

  initial begin
    logic [31:0] d;
    logic [7:0]  r;
    int          lat, lat0;
    bit          stp;

    model_reset();
    repeat (3) @(negedge clk);
    peek(A_CON, d); check("in_reset_con", d, 32'h0);
    check("in_reset_txd_line", {31'b0, uart_txd}, 32'd1);
    reset = 1'b1;
    check_regs("reset");
    check("reset_line", {31'b0, uart_txd}, 32'd1);

    // Transmit path
    con_write(32'h1);
    tx_frame(8'hA5, 1'b1);
    con_write(32'h5);
    check_regs("tx_w1c");
    for (int i = 0; i < 2; i++) begin
      r = 8'($urandom);
      tx_frame(r, 1'b0);
      check_regs("tx_rand");
      con_write(32'h4);
    end

    // Unmapped accesses
    bus_write(A_NONE, 32'hFFFF_FFFF);
    peek(A_NONE, d); check("unmapped_read", d, 32'h0);
    check_regs("unmapped_wr");

    // Receive path
    con_write(32'h2);
    rx_frame(8'h5A, 1'b1, 0, lat0);
    check("rx_latency", {31'b0, (lat0 >= 150 && lat0 <= 162)}, 32'd1);
    check_regs("rx_5a");
    bus_read(A_RXD, d); check("rx_read_5a", d, 32'h5A);
    m_rx_valid = 0;
    check_regs("rx_cleared");

    r = 8'($urandom);
    rx_frame(r, 1'b1, 0, lat);
    rx_frame(8'h11, 1'b1, 0, lat);
    check_regs("rx_overrun");
    con_write(32'h22);
    check_regs("rx_ovr_w1c");

    r = 8'($urandom);
    rx_frame(r, 1'b1, lat0, lat);
    check_regs("rx_same_edge_read");
    bus_read(A_RXD, d); check("rx_read_same", d, {24'b0, m_rx_byte});
    m_rx_valid = 0;

    r = 8'($urandom);
    rx_frame(r, 1'b0, 0, lat);
    check_regs("rx_frame_err");
    con_write(32'h42);
    check_regs("rx_ferr_w1c");

    @(negedge clk); uart_rxd = 1'b0;
    repeat (4) @(negedge clk);
    uart_rxd = 1'b1;
    repeat (40) @(negedge clk);
    check_regs("rx_glitch");
    rx_frame(8'h80, 1'b1, 0, lat);
    check_regs("rx_80");

    for (int i = 0; i < 4; i++) begin
      r   = 8'($urandom);
      stp = ($urandom_range(0, 3) != 0);
      rx_frame(r, stp, 0, lat);
      check_regs("rx_rand");
      if ($urandom_range(0, 1) == 1) begin
        bus_read(A_RXD, d); check("rx_rand_read", d, {24'b0, m_rx_byte});
        m_rx_valid = 0;
      end
    end

    // Reset in the middle of a transmit frame
    con_write(32'h3);
    @(negedge clk);
    addr = A_TXD; wdata = 32'h00; wr = 1'b1;
    @(negedge clk);
    wr = 1'b0;
    repeat (50) @(negedge clk);
    check("pre_reset_line_low", {31'b0, uart_txd}, 32'd0);
    reset = 1'b0;
    #1;
    model_reset();
    check("mid_reset_line", {31'b0, uart_txd}, 32'd1);
    check("mid_reset_irq", {31'b0, irqout}, 32'd0);
    peek(A_CON, d); check("mid_reset_con", d, 32'h0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (5) @(negedge clk);
    check("post_reset_line", {31'b0, uart_txd}, 32'd1);
    check_regs("post_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    failures++;
    $display("FAIL watchdog observed=timeout expected=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
